// File: rtl/cluster_addr_map_ctrl.sv
// rtl/cluster_addr_map_ctrl.sv - cluster address-map controller with drain-and-swap commit
// Optional drain timeout: define CLUSTER_ADDR_MAP_TIMEOUT_EN.
module cluster_addr_map_ctrl #(
    parameter int          NB_RULES        = 3,
    parameter int          NB_PORTS        = 4,
    parameter int          ADDR_WIDTH      = 64,
    parameter int          IDX_WIDTH       = 2,
    parameter int          MAX_OUTSTANDING = 16,
    parameter logic [31:0] TCDM_SIZE       = 32'h0001_0000,
    parameter int          DRAIN_TIMEOUT   = 1024
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [5:0]                     cluster_id_i,
    input  logic                           cfg_req_i,
    input  logic                           cfg_we_i,
    input  logic [7:0]                     cfg_addr_i,
    input  logic [31:0]                    cfg_wdata_i,
    output logic                           cfg_gnt_o,
    output logic                           cfg_rvalid_o,
    output logic [31:0]                    cfg_rdata_o,
    input  logic [NB_PORTS-1:0]            ax_issue_i,
    input  logic [NB_PORTS-1:0]            resp_done_i,
    output logic                           hold_o,
    output logic [NB_RULES*ADDR_WIDTH-1:0] map_start_o,
    output logic [NB_RULES*ADDR_WIDTH-1:0] map_end_o,
    output logic [NB_RULES*IDX_WIDTH-1:0]  map_idx_o,
    output logic [NB_RULES-1:0]            map_en_o,
    output logic [NB_PORTS-1:0]            ovf_o
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {ST_ACTIVE, ST_DRAIN, ST_SWAP} state_e;

    function automatic logic [31:0] rst_start(input int r);
        if (r == 1) return 32'h0020_0000;
        if (r == 2) return 32'h0040_0000;
        return 32'h0;
    endfunction

    function automatic logic [31:0] rst_end(input int r);
        if (r == 0) return TCDM_SIZE;
        if (r == 1) return 32'h0040_0000;
        if (r == 2) return 32'h1000_0000;
        return 32'h0;
    endfunction

    logic [31:0]          sh_start_q [NB_RULES];
    logic [31:0]          sh_end_q   [NB_RULES];
    logic [IDX_WIDTH-1:0] sh_idx_q   [NB_RULES];
    logic [NB_RULES-1:0]  sh_en_q;
    logic [31:0]          ac_start_q [NB_RULES];
    logic [31:0]          ac_end_q   [NB_RULES];
    logic [IDX_WIDTH-1:0] ac_idx_q   [NB_RULES];
    logic [NB_RULES-1:0]  ac_en_q;

    state_e               state_q;
    logic                 hold_q;
    logic                 pending_q;
    logic                 timeout_err;
    logic [CW-1:0]        cnt_q [NB_PORTS];
    logic [NB_PORTS-1:0]  ovf_q;
    logic                 rvalid_q;
    logic [31:0]          rdata_q;
    logic [31:0]          addr_ext;
    logic                 wr;
    logic                 commit_wr;
    logic                 idle;
    logic [31:0]          rd_val;
    logic [31:0]          base32;
    logic [ADDR_WIDTH-1:0] base_w;

`ifdef CLUSTER_ADDR_MAP_TIMEOUT_EN
    localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(DRAIN_TIMEOUT - 1);
    logic [TW-1:0] tmo_q;
    logic          tmo_err_q;
    assign timeout_err = tmo_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign addr_ext  = {24'b0, cfg_addr_i};
    assign wr        = cfg_req_i & cfg_we_i;
    assign commit_wr = wr && (addr_ext == 32'(4 * NB_RULES)) && cfg_wdata_i[0];
    assign cfg_gnt_o    = cfg_req_i;
    assign cfg_rvalid_o = rvalid_q;
    assign cfg_rdata_o  = rdata_q;
    assign hold_o       = hold_q;
    assign ovf_o        = ovf_q;
    assign map_en_o     = ac_en_q;

    always_comb begin
        idle = (ax_issue_i == '0);
        for (int p = 0; p < NB_PORTS; p++) begin
            if (cnt_q[p] != '0) idle = 1'b0;
        end
    end

    always_comb begin
        rd_val = '0;
        for (int r = 0; r < NB_RULES; r++) begin
            if (addr_ext == 32'(4 * r))     rd_val = sh_start_q[r];
            if (addr_ext == 32'(4 * r + 1)) rd_val = sh_end_q[r];
            if (addr_ext == 32'(4 * r + 2)) rd_val = {{(31 - IDX_WIDTH){1'b0}}, sh_idx_q[r], sh_en_q[r]};
        end
        if (addr_ext == 32'(4 * NB_RULES + 1))
            rd_val = {29'b0, pending_q, timeout_err, state_q != ST_ACTIVE};
    end

    // Map outputs are relative to a per-cluster base, re-added combinationally.
    assign base32 = 32'h1000_0000 + {4'b0, cluster_id_i, 22'b0};
    assign base_w = ADDR_WIDTH'(base32);

    always_comb begin
        map_start_o = '0;
        map_end_o   = '0;
        map_idx_o   = '0;
        for (int r = 0; r < NB_RULES; r++) begin
            map_start_o[r*ADDR_WIDTH +: ADDR_WIDTH] = base_w + ADDR_WIDTH'(ac_start_q[r]);
            map_end_o[r*ADDR_WIDTH +: ADDR_WIDTH]   = base_w + ADDR_WIDTH'(ac_end_q[r]);
            map_idx_o[r*IDX_WIDTH +: IDX_WIDTH]     = ac_idx_q[r];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NB_RULES; r++) begin
                sh_start_q[r] <= rst_start(r);
                sh_end_q[r]   <= rst_end(r);
                sh_idx_q[r]   <= (r < 3) ? IDX_WIDTH'(r) : '0;
                sh_en_q[r]    <= (r < 3);
            end
        end else if (wr) begin
            for (int r = 0; r < NB_RULES; r++) begin
                if (addr_ext == 32'(4 * r))     sh_start_q[r] <= cfg_wdata_i;
                if (addr_ext == 32'(4 * r + 1)) sh_end_q[r]   <= cfg_wdata_i;
                if (addr_ext == 32'(4 * r + 2)) begin
                    sh_en_q[r]  <= cfg_wdata_i[0];
                    sh_idx_q[r] <= cfg_wdata_i[IDX_WIDTH:1];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= cfg_req_i;
            if (cfg_req_i) rdata_q <= cfg_we_i ? '0 : rd_val;
        end
    end

    // Counters saturate at both ends; the sticky flag records the lost event.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int p = 0; p < NB_PORTS; p++) cnt_q[p] <= '0;
            ovf_q <= '0;
        end else begin
            for (int p = 0; p < NB_PORTS; p++) begin
                case ({ax_issue_i[p], resp_done_i[p]})
                    2'b10: if (cnt_q[p] == CW'(MAX_OUTSTANDING)) ovf_q[p] <= 1'b1;
                           else cnt_q[p] <= cnt_q[p] + 1'b1;
                    2'b01: if (cnt_q[p] == '0) ovf_q[p] <= 1'b1;
                           else cnt_q[p] <= cnt_q[p] - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_ACTIVE;
            hold_q    <= 1'b0;
            pending_q <= 1'b0;
            for (int r = 0; r < NB_RULES; r++) begin
                ac_start_q[r] <= rst_start(r);
                ac_end_q[r]   <= rst_end(r);
                ac_idx_q[r]   <= (r < 3) ? IDX_WIDTH'(r) : '0;
                ac_en_q[r]    <= (r < 3);
            end
`ifdef CLUSTER_ADDR_MAP_TIMEOUT_EN
            tmo_q     <= '0;
            tmo_err_q <= 1'b0;
`endif
        end else begin
`ifdef CLUSTER_ADDR_MAP_TIMEOUT_EN
            if (commit_wr) tmo_err_q <= 1'b0;
`endif
            case (state_q)
                ST_ACTIVE: begin
                    if (commit_wr || pending_q) begin
                        state_q   <= ST_DRAIN;
                        hold_q    <= 1'b1;
                        pending_q <= 1'b0;
`ifdef CLUSTER_ADDR_MAP_TIMEOUT_EN
                        tmo_q     <= '0;
`endif
                    end
                end
                ST_DRAIN: begin
                    if (commit_wr) pending_q <= 1'b1;
                    if (idle) begin
                        state_q <= ST_SWAP;
                    end
`ifdef CLUSTER_ADDR_MAP_TIMEOUT_EN
                    else if (tmo_q == TMO_LAST) begin
                        state_q   <= ST_ACTIVE;
                        hold_q    <= 1'b0;
                        pending_q <= 1'b0;
                        tmo_err_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                ST_SWAP: begin
                    if (commit_wr) pending_q <= 1'b1;
                    for (int r = 0; r < NB_RULES; r++) begin
                        ac_start_q[r] <= sh_start_q[r];
                        ac_end_q[r]   <= sh_end_q[r];
                        ac_idx_q[r]   <= sh_idx_q[r];
                        ac_en_q[r]    <= sh_en_q[r];
                    end
                    state_q <= ST_ACTIVE;
                    hold_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_ACTIVE;
                    hold_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/cluster_addr_map_ctrl.md
CLUSTER_ADDR_MAP_CTRL -- requirements
Module: cluster_addr_map_ctrl

Interface
REQ-001 SHALL have parameter NB_RULES, default 3: number of address-map rules.
REQ-002 SHALL have parameter NB_PORTS, default 4: number of tracked crossbar slave ports.
REQ-003 SHALL have parameter ADDR_WIDTH, default 64: rule address width.
REQ-004 SHALL have parameter IDX_WIDTH, default 2: master-port index width.
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 16: per-port outstanding limit; counter width $clog2(MAX_OUTSTANDING+1).
REQ-006 SHALL have parameter TCDM_SIZE, default 32'h0001_0000: reset size of rule 0.
REQ-007 SHALL have parameter DRAIN_TIMEOUT, default 1024: drain cycle limit, used only under the timeout feature.
REQ-008 clk_i  in  1  clock, rising edge.
REQ-009 rst_ni  in  1  reset; one clock, reset asynchronous and active-low.
REQ-010 cluster_id_i  in  6  cluster id, static strap.
REQ-011 cfg_req_i / cfg_we_i  in  1 / 1  config request / write enable.
REQ-012 cfg_addr_i / cfg_wdata_i  in  8 / 32  word index / write data.
REQ-013 cfg_gnt_o  out  1  grant; cfg_rvalid_o  out  1  response valid; cfg_rdata_o  out  32  read data.
REQ-014 ax_issue_i / resp_done_i  in  NB_PORTS / NB_PORTS  per port: AR/AW accepted / last R or B accepted.
REQ-015 hold_o  out  1  crossbar SHALL stall new AR/AW while high.
REQ-016 map_start_o / map_end_o  out  NB_RULES*ADDR_WIDTH  active rule start / end (exclusive).
REQ-017 map_idx_o  out  NB_RULES*IDX_WIDTH; map_en_o  out  NB_RULES; ovf_o  out  NB_PORTS  sticky counter over/underflow.

Function
REQ-018 base SHALL be 32'h1000_0000 + (cluster_id_i << 22), zero-extended to ADDR_WIDTH; map_start_o/map_end_o = base + active offset, modulo 2^ADDR_WIDTH, combinational from active registers.
REQ-019 Register map: index 4r = START_OFF, 4r+1 = END_OFF, 4r+2 = CFG {bit0 en, bits[IDX_WIDTH:1] idx}, 4r+3 reserved (reads 0); index 4*NB_RULES = CTRL (wr bit0 commit); 4*NB_RULES+1 = STATUS {bit0 busy, bit1 timeout_err, bit2 commit_pending}, read-only.
REQ-020 Writes SHALL update shadow registers only; reads SHALL return shadow values; unmapped indexes read 0, writes ignored.
REQ-021 cfg_gnt_o SHALL equal cfg_req_i combinationally; cfg_rvalid_o SHALL pulse one cycle after each grant, reads and writes alike.
REQ-022 Per-port counter: +1 on ax_issue_i, -1 on resp_done_i, unchanged on both; increment at MAX_OUTSTANDING or decrement at 0 SHALL saturate and set ovf_o bit.
REQ-023 FSM ACTIVE: hold_o=0; CTRL commit write -> DRAIN next cycle.
REQ-024 FSM DRAIN: hold_o=1; when all counters 0 and no ax_issue_i asserted -> SWAP.
REQ-025 FSM SWAP: hold_o=1; shadow copied to active at this clock edge -> ACTIVE; map outputs change exactly once per commit.
REQ-026 Commit written in DRAIN or SWAP SHALL set commit_pending; on return to ACTIVE a pending commit SHALL enter DRAIN next cycle and clear pending.
REQ-027 Shadow writes during DRAIN SHALL be accepted and included in that swap.
REQ-028 busy SHALL be 1 in DRAIN and SWAP.

Reset
REQ-029 On rst_ni low: FSM ACTIVE, hold_o=0, counters 0, ovf_o=0, cfg_rvalid_o=0, cfg_rdata_o=0, status bits 0.
REQ-030 Active and shadow reset values: rule0 [0, TCDM_SIZE) idx0; rule1 [0x20_0000, 0x40_0000) idx1; rule2 [0x40_0000, 0x1000_0000) idx2; all enabled; rules >=3 zero, disabled.
REQ-031 Reset mid-DRAIN SHALL discard the commit and restore reset map.

Configuration
REQ-032 Macro CLUSTER_ADDR_MAP_TIMEOUT_EN defined: DRAIN counts cycles; at DRAIN_TIMEOUT cycles SHALL go to ACTIVE without swap, set timeout_err, clear pending; timeout_err cleared by next CTRL commit.
REQ-033 Macro undefined: DRAIN waits indefinitely; timeout_err reads 0; no timeout counter present.

Verification
REQ-034 Reset, cluster_id_i=1 -> map_start_o rule0 = 0x1040_0000, map_end_o rule0 = 0x1041_0000, hold_o=0.
REQ-035 Write START_OFF rule1 = 0x30_0000, commit, no traffic -> hold_o high exactly 2 cycles, then rule1 start = base+0x30_0000.
REQ-036 Port0 issues 3, commit, port0 completes 3 over 10 cycles -> hold_o stays 1 until count 0, swap on following SWAP cycle.
REQ-037 Simultaneous issue+done on port2 with count 5 -> count stays 5; done at count 0 -> ovf_o[2]=1, count 0.
REQ-038 Commit during DRAIN -> STATUS commit_pending=1, second DRAIN begins 1 cycle after return to ACTIVE.
REQ-039 With CLUSTER_ADDR_MAP_TIMEOUT_EN, DRAIN_TIMEOUT=8, port stuck at 1 -> ACTIVE after 8 cycles, timeout_err=1, map unchanged.
